// File: rtl/reg_hazard_scoreboard.sv
// Hazard scoreboard: forwarding selects, ID stall, long-op busy/countdown.
// Ports: clk, reset (async high), ID sources, EX/MEM/WB one-hot write masks,
// long-op issue; outputs Stall, FwdRsSel/FwdRtSel, BusyMask, LongBusy,
// LongWbValid/LongWbRd. Optional macro STALL_COUNT_EN adds StallCount[15:0].
module reg_hazard_scoreboard #(
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IdValid,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        IdUsesRs,
  input  logic        IdUsesRt,
  input  logic [31:0] ExRdMask,
  input  logic [31:0] MemRdMask,
  input  logic [31:0] WbRdMask,
  input  logic        ExIsLoad,
  input  logic        IssueLong,
  input  logic [4:0]  IssueLongRd,
  output logic        Stall,
  output logic [1:0]  FwdRsSel,
  output logic [1:0]  FwdRtSel,
  output logic [31:0] BusyMask,
`ifdef STALL_COUNT_EN
  output logic [15:0] StallCount,
`endif
  output logic        LongBusy,
  output logic        LongWbValid,
  output logic [4:0]  LongWbRd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        busy_q, busy_d;
  logic [4:0]         wbrd_q, wbrd_d;

  // Register 0 is hardwired, so it never produces a hazard.
  function automatic logic hit(
    input logic        en,
    input logic [4:0]  r,
    input logic [31:0] m
  );
    return en & (r != 5'd0) & m[r];
  endfunction

  logic rs_ex, rs_mem, rs_wb, rs_busy;
  logic rt_ex, rt_mem, rt_wb, rt_busy;
  logic load_use, busy_use, struct_hz, waw_hz;
  logic accept;

  assign rs_ex   = hit(IdUsesRs, IdRs, ExRdMask);
  assign rs_mem  = hit(IdUsesRs, IdRs, MemRdMask);
  assign rs_wb   = hit(IdUsesRs, IdRs, WbRdMask);
  assign rs_busy = hit(IdUsesRs, IdRs, busy_q);
  assign rt_ex   = hit(IdUsesRt, IdRt, ExRdMask);
  assign rt_mem  = hit(IdUsesRt, IdRt, MemRdMask);
  assign rt_wb   = hit(IdUsesRt, IdRt, WbRdMask);
  assign rt_busy = hit(IdUsesRt, IdRt, busy_q);

  assign load_use  = ExIsLoad & (rs_ex | rt_ex);
  assign busy_use  = rs_busy | rt_busy;
  assign struct_hz = IssueLong & LongBusy;
  assign waw_hz    = IssueLong &
                     (ExRdMask[IssueLongRd] |
                      MemRdMask[IssueLongRd]);

  assign Stall = IdValid &
                 (load_use | busy_use | struct_hz | waw_hz);

  // Youngest producer wins: EX, then MEM, then WB.
  always_comb begin
    FwdRsSel = 2'd0;
    if (IdValid) begin
      if (rs_ex)       FwdRsSel = 2'd1;
      else if (rs_mem) FwdRsSel = 2'd2;
      else if (rs_wb)  FwdRsSel = 2'd3;
    end
  end

  always_comb begin
    FwdRtSel = 2'd0;
    if (IdValid) begin
      if (rt_ex)       FwdRtSel = 2'd1;
      else if (rt_mem) FwdRtSel = 2'd2;
      else if (rt_wb)  FwdRtSel = 2'd3;
    end
  end

  // Stall already blocks issue while BUSY (structural hazard).
  assign accept = IdValid & IssueLong & ~Stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    wbrd_d  = wbrd_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LONG_LAT - 1);
          wbrd_d  = IssueLongRd;
          busy_d  = (IssueLongRd != 5'd0) ?
                    (32'd1 << IssueLongRd) : 32'd0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Bit clears on entry to DONE so a dependent
        // instruction is released in the writeback cycle.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          busy_d  = 32'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      wbrd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      wbrd_q  <= wbrd_d;
    end
  end

  assign BusyMask    = busy_q;
  assign LongBusy    = (state_q == BUSY);
  assign LongWbValid = (state_q == DONE);
  assign LongWbRd    = wbrd_q;

`ifdef STALL_COUNT_EN
  logic [15:0] scnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt_q <= '0;
    end else if (Stall && scnt_q != 16'hFFFF) begin
      scnt_q <= scnt_q + 16'd1;
    end
  end

  assign StallCount = scnt_q;
`endif

endmodule

// File: doc/reg_hazard_scoreboard.md
Name: reg_hazard_scoreboard

Overview:
Consumer side of the per-stage register-usage masks. Takes the one-hot pending-write masks from EX/MEM/WB and the ID-stage source register indices, then produces forwarding selects and the ID stall. Also owns a registered busy bitmap and countdown for one outstanding long-latency op (mult/div), and emits its writeback pulse. Sits between decode and the forwarding muxes.

Parameters:
LONG_LAT, 4, cycles from long-op issue to result valid (legal range 2..15)
CNT_W, 4, width of the long-op countdown register

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
IdValid  in  1  ID holds a valid instruction
IdRs  in  5  ID source register 1 index
IdRt  in  5  ID source register 2 index
IdUsesRs  in  1  instruction reads Rs
IdUsesRt  in  1  instruction reads Rt
ExRdMask  in  32  one-hot pending write in EX (all-zero = none)
MemRdMask  in  32  one-hot pending write in MEM
WbRdMask  in  32  one-hot pending write in WB
ExIsLoad  in  1  EX instruction is a load
IssueLong  in  1  ID instruction is a long-latency op
IssueLongRd  in  5  destination of that long op
Stall  out  1  hold PC/IF/ID, bubble into EX
FwdRsSel  out  2  0 regfile, 1 EX, 2 MEM, 3 WB
FwdRtSel  out  2  same encoding for Rt
BusyMask  out  32  registered long-op busy bitmap
LongBusy  out  1  long op outstanding
LongWbValid  out  1  one-cycle pulse: long result ready this cycle
LongWbRd  out  5  destination for LongWbValid

Behaviour:
- Reset (async, immediate): BusyMask=0, LongBusy=0, countdown=0, LongWbValid=0, LongWbRd=0. Reset mid-operation discards the outstanding op; no LongWbValid is emitted.
- Hit terms: RsHit(m) = IdUsesRs & (IdRs!=0) & m[IdRs]; likewise for Rt. Register 0 never hits, even if a mask bit 0 is set.
- FwdRsSel/FwdRtSel are combinational. Priority EX(1) > MEM(2) > WB(3) > 0, so the youngest producer wins. If IdValid=0 they are 0.
- Stall is combinational. It is high when IdValid and any of:
  - (a) load-use: ExIsLoad & (RsHit(ExRdMask) | RtHit(ExRdMask));
  - (b) RsHit(BusyMask) | RtHit(BusyMask);
  - (c) IssueLong & LongBusy (structural, only one long op outstanding);
  - (d) IssueLong with IssueLongRd also present in ExRdMask or MemRdMask (WAW against an in-flight write).
- Long-op FSM states:
  - IDLE: LongBusy=0. On IdValid & IssueLong & !Stall: set BusyMask[IssueLongRd] (not if Rd=0), countdown<=LONG_LAT-1, LongWbRd<=IssueLongRd, go to BUSY.
  - BUSY: LongBusy=1. Countdown decrements each cycle. When countdown==1, the next edge sets LongWbValid=1, clears BusyMask[LongWbRd], and goes to DONE.
  - DONE: lasts one cycle with LongWbValid=1 and LongBusy=0. BusyMask bit is already clear, so a dependent instruction in ID this cycle does not stall on (b). Next edge goes to IDLE, or back to BUSY if a new issue is accepted this cycle (back-to-back issue allowed).
- Rd=0 long op: the full countdown and LongWbValid still occur, and BusyMask stays 0.
- LongWbValid is a registered output, high for exactly 1 cycle per accepted issue.
- BusyMask has at most one bit set at any time.

Optional Feature:
- STALL_COUNT_EN defined: adds output StallCount[15:0], registered and reset to 0. It increments on every cycle with Stall=1 and saturates at 16'hFFFF; asynchronous reset clears it.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Forwarding priority: IdRs=5, IdUsesRs=1, ExRdMask=MemRdMask=WbRdMask=1<<5, ExIsLoad=0 -> FwdRsSel=1, Stall=0. Clear ExRdMask -> FwdRsSel=2. Clear MemRdMask -> FwdRsSel=3.
- Load-use: ExIsLoad=1, ExRdMask=1<<8, IdRt=8, IdUsesRt=1 -> Stall=1, FwdRtSel=1. Same with IdRt=0 and mask bit 0 set -> Stall=0, FwdRtSel=0.
- Long op, LONG_LAT=4: issue IssueLong, Rd=12 at cycle 0 -> BusyMask=1<<12 for cycles 1..3. LongWbValid=1 with LongWbRd=12 at cycle 4 only; BusyMask=0 from cycle 4. A reader of r12 stalls cycles 1..3 and is released in cycle 4.
- Structural stall: a second IssueLong while LongBusy=1 -> Stall=1. A second IssueLong in the DONE cycle -> accepted, BusyMask takes the new Rd next cycle.
- Reset mid-op: assert reset at cycle 2 of a long op -> BusyMask=0, LongBusy=0 immediately; no LongWbValid afterwards.
- STALL_COUNT_EN: hold a stall condition for 70000 cycles -> StallCount=16'hFFFF, no wrap.
